light_timer: RTL and testbench
==============================

LIGHT_TIMER -- requirements
Module: light_timer

Interface
REQ-001 Parameter CLK_DIV, default 50_000_000, clk cycles per one-second tick (legal 2..2^26).
REQ-002 Parameter R_TIME, default 6, red phase length in ticks (1..15).
REQ-003 Parameter G_TIME, default 4, green phase length in ticks (1..15).
REQ-004 Parameter Y_TIME, default 2, yellow phase length in ticks (1..15).
REQ-005 Parameter PED_EXT, default 3, ticks the pedestrian output holds red phase (1..15).
REQ-006 Parameter DB_CYCLES, default 16, debounce stability window in clk cycles (2..2^16).
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  one clock; reset is synchronous and active-low.
REQ-009 red, green, yellow  input  1 each  current light from the downstream light controller.
REQ-010 ped_btn  input  1  raw asynchronous pedestrian push-button, active-high.
REQ-011 tick  output  1  one-cycle pulse every CLK_DIV clk cycles.
REQ-012 max_r, max_g, max_y  output  1 each  current phase time expired; controller advances on it.
REQ-013 pedestrian  output  1  pedestrian hold request to controller.
REQ-014 fault  output  1  light inputs not one-hot.

Function
REQ-015 Prescaler counts 0..CLK_DIV-1 and wraps; tick=1 for exactly the cycle the count equals CLK_DIV-1.
REQ-016 Phase register stores {red,green,yellow} each cycle; phase change = stored value differs from current inputs.
REQ-017 On phase change, 4-bit seconds counter clears to 0 and prescaler clears to 0 in the same cycle (tick suppressed that cycle).
REQ-018 Otherwise seconds counter increments on tick, saturating at 15; no wrap.
REQ-019 max_r = red & (count >= R_TIME); max_g, max_y likewise with G_TIME, Y_TIME; registered, visible one cycle after the qualifying count.
REQ-020 max_* deassert the cycle after phase change is detected; at most one max_* high at any time.
REQ-021 fault=1 when inputs are zero-hot or multi-hot; while fault, count held 0, all max_* and pedestrian forced 0.
REQ-022 ped_btn passes through a 2-flop synchroniser before any use.
REQ-023 Rising edge of the (synchronised, optionally debounced) button sets request latch; further presses while set are ignored.
REQ-024 Request latched while green or yellow: pedestrian=0 until red is entered.
REQ-025 On red entry with request set: pedestrian=1 for PED_EXT ticks counted from red entry, then pedestrian=0 and request cleared in the same cycle.
REQ-026 While pedestrian=1 the seconds counter is frozen, so max_r asserts R_TIME ticks after pedestrian falls.
REQ-027 Press while already red with pedestrian=0: request latched, served on next red entry (not current red).
REQ-028 Press in same cycle as red entry: treated as latched before entry, served immediately.

Reset
REQ-029 reset=0 sampled at a rising clk edge: prescaler=0, count=0, phase register=100 (red), request=0, synchroniser and debounce state=0.
REQ-030 During and in the cycle after reset: tick=0, max_r=max_g=max_y=0, pedestrian=0, fault=0.
REQ-031 Reset mid-phase or mid-extension discards all timing and any pending request; no output glitches to 1.

Configuration
REQ-032 Macro LIGHT_TIMER_DEBOUNCE_EN defined: synchronised button must be stable at a new level for DB_CYCLES consecutive clk cycles before the filtered level changes; REQ-023 edge taken from filtered level.
REQ-033 Macro not defined: no debounce counter instantiated; edge taken directly from synchroniser output; DB_CYCLES ignored.

Verification
REQ-034 CLK_DIV=4, reset released, red held -> tick at cycles 4,8,12,...; max_r rises one cycle after 6th tick, stays high.
REQ-035 Red->green switch while max_r=1 -> max_r=0 next cycle, count=0; max_g rises one cycle after 4th tick on green.
REQ-036 Press during green (CLK_DIV=4, PED_EXT=3) -> pedestrian=0 through green/yellow; on red entry pedestrian=1 for 3 ticks; max_r at 9th tick after red entry.
REQ-037 Inputs red=1,green=1 -> fault=1 next cycle, all max_*=0; restore red only -> fault=0, count restarts at 0.
REQ-038 DEBOUNCE_EN, DB_CYCLES=16: 10-cycle button pulse -> no request; 20-cycle pulse -> request latched; without macro both latch.
REQ-039 reset=0 asserted during pedestrian extension -> next cycle all outputs 0, request cleared, red phase timing restarts.

Source files
------------

// File: rtl/light_timer.sv
// light_timer: per-phase seconds timer for a traffic-light controller, with pedestrian hold.
// Ports: clk_i, reset_i (sync, active-low); red_i/green_i/yellow_i current light; ped_btn_i raw button;
//        tick_o 1 s pulse; max_r_o/max_g_o/max_y_o phase expired; pedestrian_o red hold; fault_o lights not one-hot.
// Optional: define LIGHT_TIMER_DEBOUNCE_EN to filter the synchronised button over DB_CYCLES clk cycles.
module light_timer #(
   parameter int CLK_DIV   = 50_000_000,
   parameter int R_TIME    = 6,
   parameter int G_TIME    = 4,
   parameter int Y_TIME    = 2,
   parameter int PED_EXT   = 3,
   parameter int DB_CYCLES = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic red_i,
   input  logic green_i,
   input  logic yellow_i,
   input  logic ped_btn_i,
   output logic tick_o,
   output logic max_r_o,
   output logic max_g_o,
   output logic max_y_o,
   output logic pedestrian_o,
   output logic fault_o
);

   // Elaboration-time parameter sanity.
   if (CLK_DIV < 2 || CLK_DIV > (1 << 26)) begin : g_bad_clk_div
      $error("light_timer: CLK_DIV out of range");
   end
   if (R_TIME < 1 || R_TIME > 15 || G_TIME < 1 || G_TIME > 15 ||
       Y_TIME < 1 || Y_TIME > 15 || PED_EXT < 1 || PED_EXT > 15) begin : g_bad_times
      $error("light_timer: phase/extension time out of range");
   end
   if (DB_CYCLES < 2 || DB_CYCLES > (1 << 16)) begin : g_bad_db
      $error("light_timer: DB_CYCLES out of range");
   end

   localparam int             PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [3:0]     R_LIM      = 4'(R_TIME);
   localparam logic [3:0]     G_LIM      = 4'(G_TIME);
   localparam logic [3:0]     Y_LIM      = 4'(Y_TIME);
   localparam logic [3:0]     PED_LAST   = 4'(PED_EXT - 1);
   localparam logic [2:0]     PH_RED     = 3'b100;

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [2:0]    phase_q, phase_d;
   logic [1:0]    sync_q, sync_d;
   logic          btn_prev_q, btn_prev_d;
   logic          req_q, req_d;
   logic          ped_q, ped_d;
   logic [3:0]    ped_cnt_q, ped_cnt_d;
   logic          max_r_q, max_r_d;
   logic          max_g_q, max_g_d;
   logic          max_y_q, max_y_d;
   logic          fault_q, fault_d;

   logic [2:0]    lights;
   logic          one_hot;
   logic          fault_now;
   logic          phase_chg;
   logic          tick_int;
   logic          red_entry;
   logic          btn_lvl;
   logic          btn_rise;
   logic          req_pend;

   assign lights    = {red_i, green_i, yellow_i};
   assign one_hot   = (red_i & ~green_i & ~yellow_i) |
                      (~red_i & green_i & ~yellow_i) |
                      (~red_i & ~green_i & yellow_i);
   assign fault_now = ~one_hot;
   assign phase_chg = (phase_q != lights);
   // A phase change restarts the second, so the tick that would have landed here is dropped.
   assign tick_int  = (presc_q == PRESC_LAST) & ~phase_chg;
   assign red_entry = phase_chg & (lights == PH_RED);

`ifdef LIGHT_TIMER_DEBOUNCE_EN
   localparam int            DW      = $clog2(DB_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

   logic          db_lvl_q, db_lvl_d;
   logic [DW-1:0] db_cnt_q, db_cnt_d;

   // Filtered level follows the synchroniser only after DB_CYCLES consecutive cycles at the new level.
   always_comb begin
      db_lvl_d = db_lvl_q;
      db_cnt_d = '0;
      if (sync_q[1] != db_lvl_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_lvl_d = sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         db_lvl_q <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         db_lvl_q <= db_lvl_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign btn_lvl = db_lvl_q;
`else
   assign btn_lvl = sync_q[1];
`endif

   assign btn_rise = btn_lvl & ~btn_prev_q;
   // A press seen in the red-entry cycle counts as already latched.
   assign req_pend = req_q | btn_rise;

   always_comb begin
      sync_d     = {sync_q[0], ped_btn_i};
      btn_prev_d = btn_lvl;
      phase_d    = lights;

      presc_d = (phase_chg || presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);

      req_d     = req_pend;
      ped_d     = ped_q;
      ped_cnt_d = ped_cnt_q;
      if (fault_now) begin
         ped_d     = 1'b0;
         ped_cnt_d = '0;
      end else if (red_entry && req_pend) begin
         ped_d     = 1'b1;
         ped_cnt_d = '0;
      end else if (phase_chg) begin
         // Leaving red mid-hold: drop the hold, keep the request for the next red.
         ped_d     = 1'b0;
         ped_cnt_d = '0;
      end else if (ped_q && tick_int) begin
         if (ped_cnt_q == PED_LAST) begin
            ped_d     = 1'b0;
            ped_cnt_d = '0;
            req_d     = 1'b0;
         end else begin
            ped_cnt_d = ped_cnt_q + 4'd1;
         end
      end

      // Seconds counter is frozen while the pedestrian hold is active.
      cnt_d = cnt_q;
      if (fault_now || phase_chg) begin
         cnt_d = '0;
      end else if (!ped_q && tick_int && cnt_q != 4'hF) begin
         cnt_d = cnt_q + 4'd1;
      end

      // Qualified on the next count so max_* shows the cycle after the expiring tick.
      max_r_d = ~fault_now & ~phase_chg & red_i    & (cnt_d >= R_LIM);
      max_g_d = ~fault_now & ~phase_chg & green_i  & (cnt_d >= G_LIM);
      max_y_d = ~fault_now & ~phase_chg & yellow_i & (cnt_d >= Y_LIM);
      fault_d = fault_now;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         presc_q    <= '0;
         cnt_q      <= '0;
         phase_q    <= PH_RED;
         sync_q     <= '0;
         btn_prev_q <= 1'b0;
         req_q      <= 1'b0;
         ped_q      <= 1'b0;
         ped_cnt_q  <= '0;
         max_r_q    <= 1'b0;
         max_g_q    <= 1'b0;
         max_y_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         sync_q     <= sync_d;
         btn_prev_q <= btn_prev_d;
         req_q      <= req_d;
         ped_q      <= ped_d;
         ped_cnt_q  <= ped_cnt_d;
         max_r_q    <= max_r_d;
         max_g_q    <= max_g_d;
         max_y_q    <= max_y_d;
         fault_q    <= fault_d;
      end
   end

   // tick is combinational off the prescaler; held low while reset is asserted.
   assign tick_o       = reset_i & tick_int;
   assign max_r_o      = max_r_q;
   assign max_g_o      = max_g_q;
   assign max_y_o      = max_y_q;
   assign pedestrian_o = ped_q;
   assign fault_o      = fault_q;

endmodule

// File: tb/tb_light_timer.sv
// Testbench for light_timer with CLK_DIV=4, R/G/Y=6/4/2, PED_EXT=3, DB_CYCLES=16.
// Inputs driven 1 time unit after posedge; outputs sampled at the following negedge.
module tb_light_timer;
   localparam int CLK_DIV   = 4;
   localparam int R_TIME    = 6;
   localparam int G_TIME    = 4;
   localparam int Y_TIME    = 2;
   localparam int PED_EXT   = 3;
   localparam int DB_CYCLES = 16;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] Y = 3'b001;

`ifdef LIGHT_TIMER_DEBOUNCE_EN
   localparam int RISE_OFS  = 2 + DB_CYCLES;
   localparam int SHORT_EXP = 0;
`else
   localparam int RISE_OFS  = 2;
   localparam int SHORT_EXP = 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic red = 1'b1, green = 1'b0, yellow = 1'b0, btn = 1'b0;
   logic tick, max_r, max_g, max_y, ped, fault;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   light_timer #(
      .CLK_DIV(CLK_DIV), .R_TIME(R_TIME), .G_TIME(G_TIME), .Y_TIME(Y_TIME),
      .PED_EXT(PED_EXT), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk_i(clk), .reset_i(rst_n), .red_i(red), .green_i(green), .yellow_i(yellow),
      .ped_btn_i(btn), .tick_o(tick), .max_r_o(max_r), .max_g_o(max_g), .max_y_o(max_y),
      .pedestrian_o(ped), .fault_o(fault)
   );

   // obs = {tick, max_r, max_g, max_y, pedestrian, fault}
   logic [5:0] obs;

   typedef struct packed {
      logic       rst_n;
      logic [2:0] rgy;
      logic [5:0] exp;
   } vec_t;

   vec_t       vecs [0:19];
   logic [5:0] sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // One clock cycle: drive, sample at negedge, return just after the posedge.
   task automatic cyc(input logic r_n, input logic [2:0] rgy, input logic b);
      #1;
      rst_n = r_n;
      {red, green, yellow} = rgy;
      btn = b;
      @(negedge clk);
      obs = {tick, max_r, max_g, max_y, ped, fault};
      @(posedge clk);
   endtask

   task automatic do_reset();
      cyc(1'b0, R, 1'b0);
      cyc(1'b0, R, 1'b0);
   endtask

   // Press for len cycles during green, then enter red; returns pedestrian one cycle later.
   task automatic ped_after_pulse(input int len, output logic got);
      do_reset();
      for (int c = 0; c < 5; c++) cyc(1'b1, G, 1'b0);
      for (int c = 0; c < len; c++) cyc(1'b1, G, 1'b1);
      for (int c = 0; c < 40; c++) cyc(1'b1, G, 1'b0);
      cyc(1'b1, R, 1'b0);
      cyc(1'b1, R, 1'b0);
      got = obs[1];
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   first, nt, bad, pcnt, pfirst, plast, mfirst;
      logic got;
      logic [5:0] e;

      // ---------------- table: reset, tick timing, fault, suppressed tick ----------------
      vecs[0]  = '{1'b0, R,      6'b000000};
      vecs[1]  = '{1'b1, R,      6'b000000};
      vecs[2]  = '{1'b1, R,      6'b000000};
      vecs[3]  = '{1'b1, R,      6'b000000};
      vecs[4]  = '{1'b1, R,      6'b100000};
      vecs[5]  = '{1'b1, 3'b110, 6'b000000};
      vecs[6]  = '{1'b1, 3'b110, 6'b000001};
      vecs[7]  = '{1'b1, R,      6'b000001};
      vecs[8]  = '{1'b1, R,      6'b000000};
      vecs[9]  = '{1'b1, R,      6'b000000};
      vecs[10] = '{1'b1, R,      6'b000000};
      vecs[11] = '{1'b1, R,      6'b100000};
      vecs[12] = '{1'b1, 3'b000, 6'b000000};
      vecs[13] = '{1'b1, 3'b000, 6'b000001};
      vecs[14] = '{1'b1, R,      6'b000001};
      vecs[15] = '{1'b1, R,      6'b000000};
      vecs[16] = '{1'b1, R,      6'b000000};
      vecs[17] = '{1'b1, R,      6'b000000};
      vecs[18] = '{1'b1, G,      6'b000000};
      vecs[19] = '{1'b1, G,      6'b000000};

      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         sb_q.push_back(vecs[i].exp);
         cyc(vecs[i].rst_n, vecs[i].rgy, 1'b0);
         if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("vec%0d", i), obs, e);
         end
      end

      // ---------------- red held from reset: tick period and max_r ----------------
      do_reset();
      first = 0; nt = 0;
      for (int c = 1; c <= 60 && first == 0; c++) begin
         cyc(1'b1, R, 1'b0);
         if (obs[4]) first = c;
         else if (obs[5]) nt++;
      end
      check("max_r_rise_cycle", first, 25);
      check("ticks_before_max_r", nt, 6);
      bad = 0; nt = 0;
      for (int c = 0; c < 80; c++) begin
         cyc(1'b1, R, 1'b0);
         if (obs[4:2] != 3'b100) bad++;
         if (obs[5]) nt++;
      end
      check("max_r_holds_saturated", bad, 0);
      check("tick_count_80", nt, 20);

      // ---------------- red -> green -> yellow ----------------
      cyc(1'b1, G, 1'b0);
      check("max_r_before_switch", obs[4], 1);
      first = 0;
      for (int c = 1; c <= 40 && first == 0; c++) begin
         cyc(1'b1, G, 1'b0);
         if (c == 1) check("max_r_clear_on_green", obs[4:2], 3'b000);
         if (obs[3]) first = c;
      end
      check("max_g_rise_cycle", first, 17);
      cyc(1'b1, Y, 1'b0);
      first = 0;
      for (int c = 1; c <= 40 && first == 0; c++) begin
         cyc(1'b1, Y, 1'b0);
         if (c == 1) check("max_g_clear_on_yellow", obs[4:2], 3'b000);
         if (obs[2]) first = c;
      end
      check("max_y_rise_cycle", first, 9);

      // ---------------- press during green, served on red entry ----------------
      do_reset();
      pcnt = 0;
      for (int c = 0; c < 40; c++) begin
         cyc(1'b1, G, (c >= 5 && c < 35));
         pcnt += int'(obs[1]);
      end
      for (int c = 0; c < 20; c++) begin
         cyc(1'b1, Y, 1'b0);
         pcnt += int'(obs[1]);
      end
      check("ped_low_green_yellow", pcnt, 0);
      cyc(1'b1, R, 1'b0);
      pcnt = 0; pfirst = 0; plast = 0; mfirst = 0;
      for (int c = 1; c <= 60; c++) begin
         cyc(1'b1, R, 1'b0);
         if (obs[1]) begin
            pcnt++;
            if (pfirst == 0) pfirst = c;
            plast = c;
         end
         if (obs[4] && mfirst == 0) mfirst = c;
      end
      check("ped_first_cycle", pfirst, 1);
      check("ped_high_cycles", pcnt, 12);
      check("ped_last_cycle", plast, 12);
      check("max_r_after_ped", mfirst, 37);

      // ---------------- press while red: deferred to next red ----------------
      do_reset();
      pcnt = 0;
      for (int c = 0; c < 70; c++) begin
         cyc(1'b1, R, (c < 25));
         pcnt += int'(obs[1]);
      end
      check("ped_not_in_current_red", pcnt, 0);
      for (int c = 0; c < 10; c++) cyc(1'b1, G, 1'b0);
      cyc(1'b1, R, 1'b0);
      cyc(1'b1, R, 1'b0);
      check("ped_served_next_red", obs[1], 1);

      // ---------------- press lands exactly on red entry ----------------
      do_reset();
      for (int c = 0; c < 10; c++) cyc(1'b1, G, 1'b0);
      for (int c = 0; c < RISE_OFS; c++) cyc(1'b1, G, 1'b1);
      cyc(1'b1, R, 1'b1);
      cyc(1'b1, R, 1'b1);
      check("ped_same_cycle_entry", obs[1], 1);

      // ---------------- pulse length vs debounce ----------------
      ped_after_pulse(10, got);
      check("pulse10_latch", got, SHORT_EXP);
      ped_after_pulse(20, got);
      check("pulse20_latch", got, 1);

      // ---------------- reset during pedestrian extension ----------------
      do_reset();
      for (int c = 0; c < 40; c++) cyc(1'b1, G, (c >= 2 && c < 32));
      cyc(1'b1, R, 1'b0);
      for (int c = 0; c < 5; c++) cyc(1'b1, R, 1'b0);
      check("ped_before_reset", obs[1], 1);
      cyc(1'b0, R, 1'b0);
      cyc(1'b1, R, 1'b0);
      check("outputs_after_reset", obs, 6'b000000);
      mfirst = 0; pcnt = 0;
      for (int c = 2; c <= 60; c++) begin
         cyc(1'b1, R, 1'b0);
         if (obs[4] && mfirst == 0) mfirst = c;
         pcnt += int'(obs[1]);
      end
      check("max_r_restart_after_reset", mfirst, 25);
      check("ped_low_after_reset", pcnt, 0);
      for (int c = 0; c < 5; c++) cyc(1'b1, G, 1'b0);
      cyc(1'b1, R, 1'b0);
      cyc(1'b1, R, 1'b0);
      check("request_cleared_by_reset", obs[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
